bet_keypad_entry: RTL
=====================

// Module: bet_keypad_entry
// PURPOSE
//  Upstream of the slot-machine core: scans a 4x4 PMOD keypad, debounces keys, and builds a decimal bet of up to 4 digits.
//  On ENTER it checks the bet against the current balance, then drives the committed bet into the core's bet input.
//  Also exposes the in-progress entry for the 7-seg mux while bet_mode is active.
// PARAMETERS
//  SCAN_DIV        100_000  clk cycles per column slot (1 ms @ 100 MHz)
//  DEBOUNCE_FRAMES 4        consecutive identical full scan frames needed to accept a press or a release
//  DEFAULT_BET     100      bet value after reset
// PORTS
//  clk          in   1   100 MHz master clock
//  rst          in   1   synchronous, active-low reset
//  enable       in   1   bet_mode switch; entry accepted only while high
//  balance      in   16  current balance from core, binary
//  row          in   4   keypad rows, active-low, pulled up externally
//  col          out  4   keypad columns, exactly one driven low at a time
//  bet          out  16  committed bet, binary, always 1..9999 once balance>=1
//  bet_valid    out  1   1-cycle pulse when bet is updated by ENTER
//  entry        out  16  in-progress value, binary (0..9999)
//  entry_digits out  3   digits typed so far (0..4)
//  err          out  1   1-cycle pulse on rejected key/commit
// BEHAVIOUR
//  Reset (rst==0 at posedge): col=4'b1110, bet=DEFAULT_BET, entry=0, entry_digits=0, bet_valid=0, err=0, FSM=IDLE, debounce state cleared.
//  Scan: col_idx 0..3 advances every SCAN_DIV cycles, wraps 3->0. Rows are sampled on the last cycle of each slot.
//   A frame is 4 slots. Frame key = the single asserted (row,col). Zero or >=2 asserted -> NONE.
//  Key map (row,col): r0:1 2 3 A / r1:4 5 6 B / r2:7 8 9 C / r3:0 F E D. A=ENTER, B=BACKSPACE, C=CLEAR; D/E/F ignored.
//  Debounce: a press is accepted after DEBOUNCE_FRAMES identical non-NONE frames, then key_strobe pulses once.
//   Re-arm requires DEBOUNCE_FRAMES consecutive NONE frames. No auto-repeat.
//  FSM states: IDLE, ENTRY, COMMIT.
//   IDLE: enable==0; keys ignored; entry/entry_digits held 0. enable rises -> ENTRY.
//   ENTRY, digit d:
//    - entry_digits<4: entry<=entry*10+d, and entry_digits increments unless (entry==0 && d==0).
//    - entry_digits==4: digit dropped, err pulse.
//   ENTRY, BACKSPACE: entry<=entry/10, digits-1 (saturate at 0).
//   ENTRY, CLEAR: entry=0, digits=0.
//   ENTRY, ENTER -> COMMIT (1 cycle):
//    - 1<=entry<=balance: bet<=entry, bet_valid=1, entry/digits cleared, back to ENTRY.
//    - otherwise: err=1, entry kept, back to ENTRY.
//   Any state, enable==0 -> IDLE next cycle. Partial entry discarded; bet unchanged.
//  Clamp: outside COMMIT, if bet>balance && balance!=0, then bet<=balance (no bet_valid). Balance==0 leaves bet unchanged.
//  Arithmetic: entry*10+d computed in 17 bits; max 9999 fits 14 bits. Compare is unsigned 16-bit.
//  Strobe coinciding with enable fall: enable wins, key dropped. Reset mid-scan restarts at col 0 with slot counter 0.
//  Outputs are registered; key_strobe -> entry update latency = 1 cycle; ENTER strobe -> bet_valid = 2 cycles.
// STRUCTURE
//  Shared package slot_pkg: KEY_* 4-bit codes (0-9, KEY_ENTER=A, KEY_BKSP=B, KEY_CLR=C, KEY_NONE=F), DEFAULT_BET, MAX_BET=9999.
//  Sub-module keypad_scanner: column drive, row sampling, frame decode, debounce.
//   Outputs key_code[3:0] and key_strobe. This module holds only the entry FSM and the bet register.
//  Bench uses SCAN_DIV=4, DEBOUNCE_FRAMES=2 for speed.
// TESTING
//  1 Reset, no keys -> bet=100, col=1110, bet_valid=0, entry=0.
//  2 enable=1, balance=1000, keys 2,5,0,A -> entry=250/3 digits, then bet=250, bet_valid pulses once, entry=0.
//  3 balance=300, keys 5,0,0,A -> err pulse, bet unchanged, entry=500. Then B,B,A -> bet=5.
//  4 Keys 0,0,0,A -> err (entry=0, digits=0). Keys 1,2,3,4,5 -> entry=1234, err on 5th.
//  5 Row bounce: toggle the held key for 1 frame within debounce -> no strobe. Two keys held together -> no strobe. Held 20 frames -> exactly one strobe.
//  6 bet=250, drop balance to 120 -> bet=120 with no bet_valid. Mid-entry enable=0 -> entry=0, bet=120. rst low mid-slot -> reset values.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared definitions for the slot-machine front end: keypad codes, the
// keypad layout lookup, bet limits and the bet-entry FSM state type.
package slot_pkg;

  localparam logic [3:0] KEY_0     = 4'h0;
  localparam logic [3:0] KEY_1     = 4'h1;
  localparam logic [3:0] KEY_2     = 4'h2;
  localparam logic [3:0] KEY_3     = 4'h3;
  localparam logic [3:0] KEY_4     = 4'h4;
  localparam logic [3:0] KEY_5     = 4'h5;
  localparam logic [3:0] KEY_6     = 4'h6;
  localparam logic [3:0] KEY_7     = 4'h7;
  localparam logic [3:0] KEY_8     = 4'h8;
  localparam logic [3:0] KEY_9     = 4'h9;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_D     = 4'hD;
  localparam logic [3:0] KEY_E     = 4'hE;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  localparam int DEFAULT_BET = 100;
  localparam int MAX_BET     = 9999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } entry_state_e;

  // Physical 4x4 layout: r0:1 2 3 A / r1:4 5 6 B / r2:7 8 9 C / r3:0 F E D.
  // The F key shares its code with KEY_NONE and is never acted on.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = KEY_1;     4'h1: code = KEY_2;
      4'h2: code = KEY_3;     4'h3: code = KEY_ENTER;
      4'h4: code = KEY_4;     4'h5: code = KEY_5;
      4'h6: code = KEY_6;     4'h7: code = KEY_BKSP;
      4'h8: code = KEY_7;     4'h9: code = KEY_8;
      4'hA: code = KEY_9;     4'hB: code = KEY_CLR;
      4'hC: code = KEY_0;     4'hD: code = KEY_NONE;
      4'hE: code = KEY_E;     default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner and frame debouncer for a 4x4 active-low keypad; emits one
// key_strobe per accepted press, with no auto-repeat.
module keypad_scanner
  import slot_pkg::*;
#(
  parameter int SCAN_DIV        = 100_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_strobe
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_FRAMES);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    hit_cnt;   // 0 = no key this frame, 1 = exactly one, 2 = ambiguous
  logic [3:0]    hit_code;
  logic          armed;
  logic [3:0]    cand_code;
  logic [DW-1:0] db_cnt;

  logic [3:0]    act;
  logic [2:0]    n_act;
  logic [1:0]    hit_row;
  logic          slot_end, frame_end, frame_hit;
  logic [1:0]    hit_nxt;
  logic [3:0]    code_nxt;
  logic          armed_nxt, strobe_nxt;
  logic [3:0]    cand_nxt;
  logic [DW-1:0] db_nxt;

  always_comb begin
    act       = ~row;
    n_act     = 3'(act[0]) + 3'(act[1]) + 3'(act[2]) + 3'(act[3]);
    hit_row   = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (act[r]) hit_row = 2'(r);
    end
    slot_end  = (slot_cnt == SLOT_LAST);
    frame_end = slot_end && (col_idx == 2'd3);
    hit_nxt   = hit_cnt;
    code_nxt  = hit_code;
    if (slot_end && n_act != 3'd0) begin
      if (n_act == 3'd1 && hit_cnt == 2'd0) begin
        hit_nxt  = 2'd1;
        code_nxt = key_at(hit_row, col_idx);
      end else begin
        hit_nxt  = 2'd2;
      end
    end
    frame_hit = (hit_nxt == 2'd1);
  end

  // Armed: count identical key frames toward a press. Disarmed: count empty
  // frames toward re-arming, so a held key never repeats.
  always_comb begin
    armed_nxt  = armed;
    cand_nxt   = cand_code;
    db_nxt     = db_cnt;
    strobe_nxt = 1'b0;
    if (frame_end) begin
      if (armed) begin
        if (frame_hit) begin
          if (db_cnt != '0 && code_nxt == cand_code) begin
            db_nxt = db_cnt + DW'(1);
          end else begin
            cand_nxt = code_nxt;
            db_nxt   = DW'(1);
          end
          if (db_nxt == DB_LAST) begin
            strobe_nxt = 1'b1;
            armed_nxt  = 1'b0;
            db_nxt     = '0;
          end
        end else begin
          db_nxt = '0;
        end
      end else if (!frame_hit) begin
        db_nxt = db_cnt + DW'(1);
        if (db_nxt == DB_LAST) begin
          armed_nxt = 1'b1;
          db_nxt    = '0;
        end
      end else begin
        db_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_cnt   <= '0;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      hit_cnt    <= 2'd0;
      hit_code   <= KEY_NONE;
      armed      <= 1'b1;
      cand_code  <= KEY_NONE;
      db_cnt     <= '0;
      key_code   <= KEY_NONE;
      key_strobe <= 1'b0;
    end else begin
      armed      <= armed_nxt;
      cand_code  <= cand_nxt;
      db_cnt     <= db_nxt;
      key_strobe <= strobe_nxt;
      if (strobe_nxt) key_code <= cand_nxt;
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        col      <= {col[2:0], col[3]};
        if (frame_end) begin
          hit_cnt  <= 2'd0;
          hit_code <= KEY_NONE;
        end else begin
          hit_cnt  <= hit_nxt;
          hit_code <= code_nxt;
        end
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bet_keypad_entry.sv
// Keypad bet entry: builds a decimal entry of up to 4 digits, validates it
// against the balance on ENTER and holds the committed bet for the core.
module bet_keypad_entry
  import slot_pkg::*;
#(
  parameter int SCAN_DIV        = 100_000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int DEFAULT_BET     = slot_pkg::DEFAULT_BET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] balance,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] bet,
  output logic        bet_valid,
  output logic [15:0] entry,
  output logic [2:0]  entry_digits,
  output logic        err,
  output logic [1:0]  fsm_state
);

  // bet_valid is a one-cycle pulse with no back-pressure: the consumer must
  // take bet in the cycle bet_valid is high; bet stays stable afterwards.

  logic [3:0]   key_code;
  logic         key_strobe;
  entry_state_e state, state_nxt;
  logic [15:0]  entry_nxt, bet_nxt;
  logic [2:0]   digits_nxt;
  logic         bet_valid_nxt, err_nxt;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_strobe(key_strobe)
  );

  assign fsm_state = state;

  always_comb begin
    state_nxt     = state;
    entry_nxt     = entry;
    digits_nxt    = entry_digits;
    bet_nxt       = bet;
    bet_valid_nxt = 1'b0;
    err_nxt       = 1'b0;
    if (!enable) begin
      state_nxt  = ST_IDLE;
      entry_nxt  = '0;
      digits_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt  = ST_ENTRY;
          entry_nxt  = '0;
          digits_nxt = '0;
        end
        ST_ENTRY: begin
          if (key_strobe) begin
            if (key_code <= KEY_9) begin
              if (entry_digits < 3'd4) begin
                entry_nxt = 16'(({1'b0, entry} * 17'd10) + 17'(key_code));
                // Leading zeros do not count as typed digits.
                if (!(entry == 16'd0 && key_code == KEY_0)) digits_nxt = entry_digits + 3'd1;
              end else begin
                err_nxt = 1'b1;
              end
            end else if (key_code == KEY_BKSP) begin
              entry_nxt = entry / 16'd10;
              if (entry_digits != 3'd0) digits_nxt = entry_digits - 3'd1;
            end else if (key_code == KEY_CLR) begin
              entry_nxt  = '0;
              digits_nxt = '0;
            end else if (key_code == KEY_ENTER) begin
              state_nxt = ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          state_nxt = ST_ENTRY;
          if (entry != 16'd0 && entry <= balance) begin
            bet_nxt       = entry;
            bet_valid_nxt = 1'b1;
            entry_nxt     = '0;
            digits_nxt    = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    // A shrinking balance pulls the bet down silently; zero balance leaves it.
    if (state != ST_COMMIT && bet > balance && balance != 16'd0) bet_nxt = balance;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      entry        <= '0;
      entry_digits <= '0;
      bet          <= 16'(DEFAULT_BET);
      bet_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      entry        <= entry_nxt;
      entry_digits <= digits_nxt;
      bet          <= bet_nxt;
      bet_valid    <= bet_valid_nxt;
      err          <= err_nxt;
    end
  end

endmodule
